// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi ACS sequencer: FSM state encoding,
// trellis size, default metric width and the frame-start metric vector.
package viterbi_pkg;

    localparam int VIT_NUM_STATES   = 4;
    localparam int VIT_PM_W_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_DONE
    } vit_state_e;

    // Largest representable path metric for a given width (all ones).
    function automatic logic [31:0] vitPmMax(input int pmW);
        return (32'h1 << pmW) - 32'h1;
    endfunction

    // Frame-start metric for trellis state idx: state 0 is the known start
    // state, every other state begins as "maximally unlikely".
    function automatic logic [31:0] vitPmInit(input int idx, input int pmW);
        return (idx == 0) ? 32'h0 : vitPmMax(pmW);
    endfunction

endpackage

// File: rtl/viterbi_pm_min4.sv
// Combinational minimum and argmin of four path metrics.
// On equal metrics the lowest state index is reported.
module viterbi_pm_min4
    import viterbi_pkg::*;
#(
    parameter int PM_W = VIT_PM_W_DEFAULT
) (
    input  logic [PM_W-1:0] i_pm_0,
    input  logic [PM_W-1:0] i_pm_1,
    input  logic [PM_W-1:0] i_pm_2,
    input  logic [PM_W-1:0] i_pm_3,
    output logic [PM_W-1:0] o_min,
    output logic [1:0]      o_min_idx
);

    logic [PM_W-1:0] w_min_01;
    logic [PM_W-1:0] w_min_23;
    logic [1:0]      w_idx_01;
    logic [1:0]      w_idx_23;

    // Pairwise tree; strict less-than keeps the lower index on ties.
    always_comb begin
        w_min_01  = i_pm_0;
        w_idx_01  = 2'd0;
        w_min_23  = i_pm_2;
        w_idx_23  = 2'd2;
        o_min     = '0;
        o_min_idx = 2'd0;
        if (i_pm_1 < i_pm_0) begin
            w_min_01 = i_pm_1;
            w_idx_01 = 2'd1;
        end
        if (i_pm_3 < i_pm_2) begin
            w_min_23 = i_pm_3;
            w_idx_23 = 2'd3;
        end
        if (w_min_23 < w_min_01) begin
            o_min     = w_min_23;
            o_min_idx = w_idx_23;
        end else begin
            o_min     = w_min_01;
            o_min_idx = w_idx_01;
        end
    end

endmodule

// File: rtl/viterbi_acs_sequencer.sv
// Frame controller for the 4-state ACS array: owns the path-metric
// registers, captures the array's next-state metrics on each accepted beat,
// counts symbols and reports the best state at end of frame.
// Optional feature macro: VITERBI_ACS_PM_NORM_EN (min-subtraction
// normalization of captured metrics; when undefined metrics wrap raw).
module viterbi_acs_sequencer
    import viterbi_pkg::*;
#(
    parameter  int PM_W      = VIT_PM_W_DEFAULT,
    parameter  int FRAME_LEN = 16,
    localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_bm_valid,
    output logic             o_bm_ready,
    input  logic [1:0]       i_bm_0,
    input  logic [1:0]       i_bm_1,
    input  logic [1:0]       i_bm_2,
    input  logic [1:0]       i_bm_3,
    output logic [1:0]       o_acs_bm_0,
    output logic [1:0]       o_acs_bm_1,
    output logic [1:0]       o_acs_bm_2,
    output logic [1:0]       o_acs_bm_3,
    output logic [PM_W-1:0]  o_acs_pm_0,
    output logic [PM_W-1:0]  o_acs_pm_1,
    output logic [PM_W-1:0]  o_acs_pm_2,
    output logic [PM_W-1:0]  o_acs_pm_3,
    input  logic [PM_W-1:0]  i_acs_pm_0,
    input  logic [PM_W-1:0]  i_acs_pm_1,
    input  logic [PM_W-1:0]  i_acs_pm_2,
    input  logic [PM_W-1:0]  i_acs_pm_3,
    output logic [PM_W-1:0]  o_pm_0,
    output logic [PM_W-1:0]  o_pm_1,
    output logic [PM_W-1:0]  o_pm_2,
    output logic [PM_W-1:0]  o_pm_3,
    output logic [CNT_W-1:0] o_sym_cnt,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_best_state
);

    vit_state_e                                r_state;
    vit_state_e                                w_state_next;
    logic [VIT_NUM_STATES-1:0][PM_W-1:0]       r_pm;
    logic [VIT_NUM_STATES-1:0][PM_W-1:0]       w_pm_init;
    logic [VIT_NUM_STATES-1:0][PM_W-1:0]       w_pm_upd;
    logic [VIT_NUM_STATES-1:0][PM_W-1:0]       w_acs_pm;
    logic [CNT_W-1:0]                          r_sym_cnt;
    logic [1:0]                                r_best;
    logic [PM_W-1:0]                           w_reg_min;
    logic [1:0]                                w_reg_min_idx;
    logic                                      w_accept;
    logic                                      w_last;
    logic                                      w_unused;

    assign w_acs_pm = {i_acs_pm_3, i_acs_pm_2, i_acs_pm_1, i_acs_pm_0};
    assign w_accept = (r_state == ST_RUN) && i_bm_valid;
    assign w_last   = w_accept && (r_sym_cnt == CNT_W'(FRAME_LEN - 1));

    // Frame-start metric vector: state 0 at zero, the rest at PM_MAX.
    always_comb begin
        w_pm_init = '0;
        for (int k = 0; k < VIT_NUM_STATES; k++) begin
            w_pm_init[k] = PM_W'(vitPmInit(k, PM_W));
        end
    end

`ifdef VITERBI_ACS_PM_NORM_EN
    logic [PM_W-1:0] w_acs_min;
    logic [1:0]      w_acs_min_idx;

    viterbi_pm_min4 #(.PM_W(PM_W)) u_norm_min (
        .i_pm_0    (i_acs_pm_0),
        .i_pm_1    (i_acs_pm_1),
        .i_pm_2    (i_acs_pm_2),
        .i_pm_3    (i_acs_pm_3),
        .o_min     (w_acs_min),
        .o_min_idx (w_acs_min_idx)
    );

    // Subtract the smallest incoming metric so the best state sits at zero.
    always_comb begin
        w_pm_upd = '0;
        for (int k = 0; k < VIT_NUM_STATES; k++) begin
            w_pm_upd[k] = w_acs_pm[k] - w_acs_min;
        end
    end

    assign w_unused = ^{w_acs_min_idx, w_reg_min};
`else
    assign w_pm_upd = w_acs_pm;
    assign w_unused = ^w_reg_min;
`endif

    viterbi_pm_min4 #(.PM_W(PM_W)) u_best_min (
        .i_pm_0    (r_pm[0]),
        .i_pm_1    (r_pm[1]),
        .i_pm_2    (r_pm[2]),
        .i_pm_3    (r_pm[3]),
        .o_min     (w_reg_min),
        .o_min_idx (w_reg_min_idx)
    );

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-state handshake/status outputs.
    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_bm_ready   = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_INIT;
                end
            end
            ST_INIT: begin
                o_busy       = 1'b1;
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                o_busy     = 1'b1;
                o_bm_ready = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_busy       = 1'b1;
                o_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Metrics and count load on start so they are already visible during
    // INIT; afterwards they only move on an accepted beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pm      <= '0;
            r_sym_cnt <= '0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_pm      <= w_pm_init;
            r_sym_cnt <= '0;
        end else if (w_accept) begin
            r_pm      <= w_pm_upd;
            r_sym_cnt <= r_sym_cnt + CNT_W'(1);
        end
    end

    // Keep the DONE-cycle argmin so the report holds until the next frame end.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_best <= 2'd0;
        end else if (r_state == ST_DONE) begin
            r_best <= w_reg_min_idx;
        end
    end

    assign o_best_state = (r_state == ST_DONE) ? w_reg_min_idx : r_best;
    assign o_sym_cnt    = r_sym_cnt;

    assign o_acs_bm_0 = (r_state == ST_RUN) ? i_bm_0 : 2'b00;
    assign o_acs_bm_1 = (r_state == ST_RUN) ? i_bm_1 : 2'b00;
    assign o_acs_bm_2 = (r_state == ST_RUN) ? i_bm_2 : 2'b00;
    assign o_acs_bm_3 = (r_state == ST_RUN) ? i_bm_3 : 2'b00;

    assign o_acs_pm_0 = r_pm[0];
    assign o_acs_pm_1 = r_pm[1];
    assign o_acs_pm_2 = r_pm[2];
    assign o_acs_pm_3 = r_pm[3];

    assign o_pm_0 = r_pm[0];
    assign o_pm_1 = r_pm[1];
    assign o_pm_2 = r_pm[2];
    assign o_pm_3 = r_pm[3];

endmodule

// File: tb/tb_viterbi_acs_sequencer.sv
// Testbench for viterbi_acs_sequencer (PM_W=2, FRAME_LEN=4). The bench plays
// the role of the ACS array, so i_acs_pm_* is free stimulus. A frame-level
// reference model predicts every output after each clock edge.
module tb_viterbi_acs_sequencer;

    localparam int PM_W      = 2;
    localparam int FRAME_LEN = 4;
    localparam int CNT_W     = 3;
`ifdef VITERBI_ACS_PM_NORM_EN
    localparam bit NORM = 1'b1;
`else
    localparam bit NORM = 1'b0;
`endif

    typedef logic [3:0][1:0] quadT;

    typedef struct {
        logic start;
        logic valid;
        quadT acs;
        logic expBusy;
        logic expReady;
        logic expDone;
        int   expCnt;
        quadT expPm;
        logic [1:0] expBest;
    } vecT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstN, start, bmValid;
    quadT bmIn, acsIn;

    logic bmReady, busy, done;
    logic [1:0] acsBm0, acsBm1, acsBm2, acsBm3;
    logic [1:0] acsPm0, acsPm1, acsPm2, acsPm3;
    logic [1:0] pm0, pm1, pm2, pm3;
    logic [CNT_W-1:0] symCnt;
    logic [1:0] bestState;
    quadT oPm, oAcsPm, oAcsBm;

    assign oPm    = {pm3, pm2, pm1, pm0};
    assign oAcsPm = {acsPm3, acsPm2, acsPm1, acsPm0};
    assign oAcsBm = {acsBm3, acsBm2, acsBm1, acsBm0};

    viterbi_acs_sequencer #(.PM_W(PM_W), .FRAME_LEN(FRAME_LEN)) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_start      (start),
        .i_bm_valid   (bmValid),
        .o_bm_ready   (bmReady),
        .i_bm_0       (bmIn[0]),
        .i_bm_1       (bmIn[1]),
        .i_bm_2       (bmIn[2]),
        .i_bm_3       (bmIn[3]),
        .o_acs_bm_0   (acsBm0),
        .o_acs_bm_1   (acsBm1),
        .o_acs_bm_2   (acsBm2),
        .o_acs_bm_3   (acsBm3),
        .o_acs_pm_0   (acsPm0),
        .o_acs_pm_1   (acsPm1),
        .o_acs_pm_2   (acsPm2),
        .o_acs_pm_3   (acsPm3),
        .i_acs_pm_0   (acsIn[0]),
        .i_acs_pm_1   (acsIn[1]),
        .i_acs_pm_2   (acsIn[2]),
        .i_acs_pm_3   (acsIn[3]),
        .o_pm_0       (pm0),
        .o_pm_1       (pm1),
        .o_pm_2       (pm2),
        .o_pm_3       (pm3),
        .o_sym_cnt    (symCnt),
        .o_busy       (busy),
        .o_done       (done),
        .o_best_state (bestState)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model: frame phase (0 idle, 1 init, 2 run, 3 done) and data.
    int         mPhase;
    quadT       mPm;
    int         mCnt;
    logic [1:0] mBest;

    function automatic quadT pack4(input logic [1:0] a0, a1, a2, a3);
        quadT r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        return r;
    endfunction

    function automatic quadT rnd4();
        return 8'($urandom);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        mPhase = 0;
        mPm    = '0;
        mCnt   = 0;
        mBest  = 2'd0;
    endtask

    task automatic modelEdge(input logic st, input logic vld, input quadT acs);
        int mn;
        case (mPhase)
            0: if (st) begin
                mPhase = 1;
                mPm    = pack4(2'd0, 2'd3, 2'd3, 2'd3);
                mCnt   = 0;
            end
            1: mPhase = 2;
            2: if (vld) begin
                mn = 3;
                for (int k = 0; k < 4; k++) if (int'(acs[k]) < mn) mn = int'(acs[k]);
                for (int k = 0; k < 4; k++) mPm[k] = NORM ? 2'(int'(acs[k]) - mn) : acs[k];
                mCnt++;
                if (mCnt == FRAME_LEN) begin
                    mPhase = 3;
                    mBest  = 2'd0;
                    for (int k = 1; k < 4; k++) if (mPm[k] < mPm[mBest]) mBest = 2'(k);
                end
            end
            default: mPhase = 0;
        endcase
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, " busy"},  32'(busy),    32'(mPhase != 0));
        checkOutput({tag, " ready"}, 32'(bmReady), 32'(mPhase == 2));
        checkOutput({tag, " done"},  32'(done),    32'(mPhase == 3));
        checkOutput({tag, " cnt"},   32'(symCnt),  32'(mCnt));
        checkOutput({tag, " best"},  32'(bestState), 32'(mBest));
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("%s pm%0d", tag, k),     32'(oPm[k]),    32'(mPm[k]));
            checkOutput($sformatf("%s acs_pm%0d", tag, k), 32'(oAcsPm[k]), 32'(mPm[k]));
            checkOutput($sformatf("%s acs_bm%0d", tag, k), 32'(oAcsBm[k]),
                        (mPhase == 2) ? 32'(bmIn[k]) : 32'd0);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic st, input logic vld, input quadT bm, input quadT acs);
        start   = st;
        bmValid = vld;
        bmIn    = bm;
        acsIn   = acs;
        @(posedge clk);
        if (!rstN) modelReset();
        else modelEdge(st, vld, acs);
        #1;
        checkAll(tag);
    endtask

    task automatic runFrame(input string tag);
        logic seen;
        seen = 1'b0;
        applyStimulus(tag, 1'b1, 1'b0, rnd4(), rnd4());
        for (int i = 0; i < 200 && !seen; i++) begin
            applyStimulus(tag, 1'b0, 1'($urandom_range(0, 1)), rnd4(), rnd4());
            seen = done;
        end
        if (!seen) checkOutput({tag, " done_timeout"}, 32'd0, 32'd1);
        applyStimulus(tag, 1'b0, 1'b0, rnd4(), rnd4());
    endtask

    vecT  vecs[7];
    quadT acsA, initPm, expPm;
    logic bubValid[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int   bubCnt[7]   = '{1, 1, 1, 2, 3, 3, 4};
    logic bubDone[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rstN = 1'b0; start = 1'b0; bmValid = 1'b0; bmIn = '0; acsIn = '0;
        modelReset();

        // Reset held with random traffic: everything stays at zero.
        for (int i = 0; i < 3; i++) applyStimulus("reset", 1'b1, 1'b1, rnd4(), rnd4());
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus("idle", 1'b0, 1'($urandom_range(0, 1)), rnd4(), rnd4());
            checkOutput("idle_busy", 32'(busy), 32'd0);
        end

        // Full frame, fixed ACS return of {1,2,1,3} on every beat.
        acsA   = pack4(2'd1, 2'd2, 2'd1, 2'd3);
        initPm = pack4(2'd0, 2'd3, 2'd3, 2'd3);
        expPm  = NORM ? pack4(2'd0, 2'd1, 2'd0, 2'd2) : acsA;
        vecs[0] = '{1'b1, 1'b0, acsA, 1'b1, 1'b0, 1'b0, 0, initPm, 2'd0};
        vecs[1] = '{1'b0, 1'b1, acsA, 1'b1, 1'b1, 1'b0, 0, initPm, 2'd0};
        vecs[2] = '{1'b0, 1'b1, acsA, 1'b1, 1'b1, 1'b0, 1, expPm,  2'd0};
        vecs[3] = '{1'b0, 1'b1, acsA, 1'b1, 1'b1, 1'b0, 2, expPm,  2'd0};
        vecs[4] = '{1'b0, 1'b1, acsA, 1'b1, 1'b1, 1'b0, 3, expPm,  2'd0};
        vecs[5] = '{1'b0, 1'b1, acsA, 1'b1, 1'b0, 1'b1, 4, expPm,  2'd0};
        vecs[6] = '{1'b0, 1'b1, acsA, 1'b0, 1'b0, 1'b0, 4, expPm,  2'd0};
        for (int i = 0; i < 7; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].start, vecs[i].valid, rnd4(), vecs[i].acs);
            checkOutput($sformatf("vec%0d busy", i),  32'(busy),      32'(vecs[i].expBusy));
            checkOutput($sformatf("vec%0d ready", i), 32'(bmReady),   32'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d done", i),  32'(done),      32'(vecs[i].expDone));
            checkOutput($sformatf("vec%0d cnt", i),   32'(symCnt),    32'(vecs[i].expCnt));
            checkOutput($sformatf("vec%0d pm", i),    32'(oPm),       32'(vecs[i].expPm));
            checkOutput($sformatf("vec%0d best", i),  32'(bestState), 32'(vecs[i].expBest));
        end

        // Last beat returns {3,1,2,3}: state 1 must be reported and held.
        applyStimulus("best", 1'b1, 1'b0, rnd4(), acsA);
        applyStimulus("best", 1'b0, 1'b1, rnd4(), acsA);
        for (int i = 0; i < 3; i++) applyStimulus("best", 1'b0, 1'b1, rnd4(), acsA);
        applyStimulus("best_last", 1'b0, 1'b1, rnd4(), pack4(2'd3, 2'd1, 2'd2, 2'd3));
        checkOutput("best_done", 32'(done), 32'd1);
        checkOutput("best_state", 32'(bestState), 32'd1);
        if (!NORM) checkOutput("best_raw_pm", 32'(oPm), 32'(pack4(2'd3, 2'd1, 2'd2, 2'd3)));
        applyStimulus("best_hold", 1'b0, 1'b0, rnd4(), rnd4());
        checkOutput("best_hold_state", 32'(bestState), 32'd1);
        checkOutput("best_hold_done", 32'(done), 32'd0);

        // Bubbles in the valid stream: only valid beats advance the frame.
        applyStimulus("bub", 1'b1, 1'b0, rnd4(), rnd4());
        applyStimulus("bub", 1'b0, 1'b0, rnd4(), rnd4());
        for (int i = 0; i < 7; i++) begin
            applyStimulus($sformatf("bub%0d", i), 1'b0, bubValid[i], rnd4(), rnd4());
            checkOutput($sformatf("bub%0d cnt", i), 32'(symCnt), 32'(bubCnt[i]));
            checkOutput($sformatf("bub%0d done", i), 32'(done), 32'(bubDone[i]));
        end
        applyStimulus("bub_end", 1'b0, 1'b0, rnd4(), rnd4());

        // Reset in the middle of RUN at count 2, then a clean frame.
        applyStimulus("abort", 1'b1, 1'b0, rnd4(), rnd4());
        applyStimulus("abort", 1'b0, 1'b0, rnd4(), rnd4());
        applyStimulus("abort", 1'b0, 1'b1, rnd4(), rnd4());
        applyStimulus("abort", 1'b0, 1'b1, rnd4(), rnd4());
        checkOutput("abort_cnt_before", 32'(symCnt), 32'd2);
        rstN = 1'b0;
        #1;
        modelReset();
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_cnt", 32'(symCnt), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkAll("abort_async");
        applyStimulus("abort_hold", 1'b1, 1'b1, rnd4(), rnd4());
        applyStimulus("abort_hold", 1'b0, 1'b1, rnd4(), rnd4());
        rstN = 1'b1;
        runFrame("after_abort");

        // A start pulse during RUN is neither honoured nor queued.
        applyStimulus("ign", 1'b1, 1'b0, rnd4(), rnd4());
        applyStimulus("ign", 1'b0, 1'b0, rnd4(), rnd4());
        applyStimulus("ign", 1'b0, 1'b1, rnd4(), rnd4());
        applyStimulus("ign_start", 1'b1, 1'b1, rnd4(), rnd4());
        checkOutput("ign_cnt", 32'(symCnt), 32'd2);
        applyStimulus("ign", 1'b0, 1'b1, rnd4(), rnd4());
        applyStimulus("ign", 1'b0, 1'b1, rnd4(), rnd4());
        checkOutput("ign_done", 32'(done), 32'd1);
        applyStimulus("ign", 1'b0, 1'b0, rnd4(), rnd4());
        applyStimulus("ign", 1'b0, 1'b0, rnd4(), rnd4());
        checkOutput("ign_no_queue", 32'(busy), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), rnd4(), rnd4());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
